mem_port_arbiter: RTL and testbench

//  Shares one single-port synchronous memory between the CPU instruction-fetch

---
 rtl/mem_port_arbiter.sv | 71 +++++++
 tb/tb_mem_port_arbiter.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: round-robin sharing of one single-port memory between a fetch port and a data port
module mem_port_arbiter #(
  parameter int AW = 32,
  parameter int DW = 32,
  parameter int MEM_LAT = 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          req0,
  input  logic [AW-1:0] addr0,
  output logic          ack0,
  output logic [DW-1:0] rdata0,
  input  logic          req1,
  input  logic [AW-1:0] addr1,
  input  logic [DW-1:0] wdata1,
  input  logic          we1,
  output logic          ack1,
  output logic [DW-1:0] rdata1,
  output logic          mem_en,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata
);
  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, ACK} state_t;
  state_t state, state_nxt;
  logic last_gnt, gnt, we_l, take, pick, done;
  logic [3:0] cnt;
  always_comb begin
    take = state == IDLE && (req0 || req1);
    pick = req0 && req1 ? !last_gnt : req1;
    done = state == WAIT && cnt == 4'd0;
    state_nxt = state == IDLE  ? (take ? ISSUE : IDLE)
              : state == ISSUE ? WAIT
              : state == WAIT  ? (done ? ACK : WAIT)
              : IDLE;
  end
  always_ff @(posedge clk) state <= !rst ? IDLE : state_nxt;
  // mem_* are loaded at the grant edge so they are live only during ISSUE
  always_ff @(posedge clk) begin
    if (!rst) begin
      last_gnt  <= 1'b0;
      gnt       <= 1'b0;
      we_l      <= 1'b0;
      cnt       <= 4'd0;
      mem_en    <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      ack0      <= 1'b0;
      ack1      <= 1'b0;
      rdata0    <= '0;
      rdata1    <= '0;
    end else begin
      mem_en    <= take;
      mem_we    <= take && pick && we1;
      mem_addr  <= take ? (pick ? addr1 : addr0) : '0;
      mem_wdata <= take && pick ? wdata1 : '0;
      ack0      <= done && !gnt;
      ack1      <= done && gnt;
      if (take) begin
        last_gnt <= pick;
        gnt      <= pick;
        we_l     <= pick && we1;
      end
      cnt <= state == ISSUE ? 4'(MEM_LAT - 1) : (state == WAIT && cnt != 4'd0 ? cnt - 4'd1 : cnt);
      if (done && !we_l && !gnt) rdata0 <= mem_rdata;
      if (done && !we_l && gnt) rdata1 <= mem_rdata;
    end
  end
endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: two arbiters (MEM_LAT 1 and 3) checked every cycle against a transaction-level model
module tb_mem_port_arbiter;
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst [2], req0 [2], req1 [2], we1 [2], ack0 [2], ack1 [2], mem_en [2], mem_we [2];
  logic [31:0] addr0 [2], addr1 [2], wdata1 [2], rdata0 [2], rdata1 [2], mem_addr [2], mem_wdata [2];
  int cyc = 0;
  int checks = 0;
  int errors = 0;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [31:0] init_val(input logic [31:0] a);
    return a == 32'h10 ? 32'h00500093 : a == 32'h40 ? 32'h12345678 : a ^ 32'h5A5A0000;
  endfunction

  task automatic chk(input string n, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", n, got, exp);
    end
  endtask

  for (genvar k = 0; k < 2; k++) begin : g
    localparam int L = k == 0 ? 1 : 3;
    logic [31:0] rdat;
    mem_port_arbiter #(.AW(32), .DW(32), .MEM_LAT(L)) dut (
      .clk(clk), .rst(rst[k]),
      .req0(req0[k]), .addr0(addr0[k]), .ack0(ack0[k]), .rdata0(rdata0[k]),
      .req1(req1[k]), .addr1(addr1[k]), .wdata1(wdata1[k]), .we1(we1[k]),
      .ack1(ack1[k]), .rdata1(rdata1[k]),
      .mem_en(mem_en[k]), .mem_we(mem_we[k]), .mem_addr(mem_addr[k]),
      .mem_wdata(mem_wdata[k]), .mem_rdata(rdat)
    );
    // memory: read data is valid only in the cycle L after mem_en, junk otherwise
    logic [31:0] mem [logic [31:0]];
    int rd_at = -1;
    logic [31:0] rd_val = '0;
    always @(negedge clk) begin
      if (mem_en[k] === 1'b1) begin
        if (mem_we[k]) mem[mem_addr[k]] = mem_wdata[k];
        else begin
          rd_at = cyc + L;
          rd_val = mem.exists(mem_addr[k]) ? mem[mem_addr[k]] : init_val(mem_addr[k]);
        end
      end
      rdat = cyc == rd_at ? rd_val : (32'hBAD00000 | 32'(cyc));
    end
    // model: a request sampled in free cycle c issues at c+1, acks at c+L+2, frees at c+L+3
    logic [31:0] shadow [logic [31:0]];
    int free_c = 0, en_c = -1, ack_c = -1;
    bit lg, gp, gwe;
    logic [31:0] gaddr = '0, gwdata = '0, rdval = '0, exp_rd0 = '0, exp_rd1 = '0;
    always @(posedge clk) begin
      if (!rst[k]) begin
        free_c = cyc + 1;
        en_c = -1;
        ack_c = -1;
        lg = 1'b0;
        exp_rd0 = '0;
        exp_rd1 = '0;
      end else begin
        if (cyc + 1 == ack_c && !gwe) begin
          if (gp) exp_rd1 = rdval;
          else exp_rd0 = rdval;
        end
        if (cyc >= free_c && (req0[k] || req1[k])) begin
          gp = req0[k] && req1[k] ? !lg : req1[k];
          lg = gp;
          gwe = gp && we1[k];
          gaddr = gp ? addr1[k] : addr0[k];
          gwdata = wdata1[k];
          rdval = shadow.exists(gaddr) ? shadow[gaddr] : init_val(gaddr);
          if (gwe) shadow[gaddr] = gwdata;
          en_c = cyc + 1;
          ack_c = cyc + L + 2;
          free_c = cyc + L + 3;
        end
      end
    end
    always @(negedge clk) if (cyc >= 1) begin
      chk($sformatf("i%0d mem_en", k), 32'(mem_en[k]), 32'(cyc == en_c));
      chk($sformatf("i%0d mem_we", k), 32'(mem_we[k]), 32'(cyc == en_c && gwe));
      chk($sformatf("i%0d mem_addr", k), mem_addr[k], cyc == en_c ? gaddr : 32'h0);
      if (cyc == en_c && gwe) chk($sformatf("i%0d mem_wdata", k), mem_wdata[k], gwdata);
      chk($sformatf("i%0d ack0", k), 32'(ack0[k]), 32'(cyc == ack_c && !gp));
      chk($sformatf("i%0d ack1", k), 32'(ack1[k]), 32'(cyc == ack_c && gp));
      chk($sformatf("i%0d ack overlap", k), 32'(ack0[k] && ack1[k]), 32'h0);
      chk($sformatf("i%0d rdata0", k), rdata0[k], exp_rd0);
      chk($sformatf("i%0d rdata1", k), rdata1[k], exp_rd1);
    end
  end

  task automatic do_req(input int k, input bit p, input bit we, input logic [31:0] a, input logic [31:0] d,
                        output int t_req, output int t_en, output int t_ack, output int n_en,
                        output logic [31:0] e_addr, output logic e_we, output logic [31:0] e_wdata);
    @(negedge clk);
    if (p) begin
      req1[k] = 1'b1;
      we1[k] = we;
      addr1[k] = a;
      wdata1[k] = d;
    end else begin
      req0[k] = 1'b1;
      addr0[k] = a;
    end
    t_req = cyc;
    t_en = -1;
    t_ack = -1;
    n_en = 0;
    e_addr = '0;
    e_we = 1'b0;
    e_wdata = '0;
    for (int i = 0; i < 40 && t_ack < 0; i++) begin
      @(negedge clk);
      if (mem_en[k]) begin
        n_en++;
        if (t_en < 0) begin
          t_en = cyc;
          e_addr = mem_addr[k];
          e_we = mem_we[k];
          e_wdata = mem_wdata[k];
        end
      end
      if (p ? ack1[k] : ack0[k]) t_ack = cyc;
    end
    req0[k] = 1'b0;
    req1[k] = 1'b0;
    we1[k] = 1'b0;
    chk("ack seen", 32'(t_ack >= 0), 32'h1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  initial begin
    int t_req, t_en, t_ack, n_en, cnt;
    logic [31:0] e_addr, e_wdata;
    logic e_we;
    int order [$];
    int tacks [$];
    int exp_order [4] = '{1, 0, 1, 0};
    for (int k = 0; k < 2; k++) begin
      rst[k] = 1'b0;
      req0[k] = 1'b0;
      req1[k] = 1'b0;
      we1[k] = 1'b0;
      addr0[k] = '0;
      addr1[k] = '0;
      wdata1[k] = '0;
    end
    repeat (2) @(negedge clk);
    rst[0] = 1'b1;
    rst[1] = 1'b1;
    @(negedge clk);
    chk("t1 mem_en", 32'(mem_en[0]), 32'h0);
    chk("t1 ack0", 32'(ack0[0]), 32'h0);
    chk("t1 rdata0", rdata0[0], 32'h0);
    do_req(0, 1'b0, 1'b0, 32'h10, 32'h0, t_req, t_en, t_ack, n_en, e_addr, e_we, e_wdata);
    chk("t2 en latency", 32'(t_en - t_req), 32'd1);
    chk("t2 ack latency", 32'(t_ack - t_req), 32'd3);
    chk("t2 mem_addr", e_addr, 32'h10);
    chk("t2 mem_we", 32'(e_we), 32'h0);
    chk("t2 rdata0", rdata0[0], 32'h00500093);
    do_req(0, 1'b1, 1'b1, 32'h20, 32'hDEADBEEF, t_req, t_en, t_ack, n_en, e_addr, e_we, e_wdata);
    chk("t3 en count", 32'(n_en), 32'd1);
    chk("t3 mem_we", 32'(e_we), 32'h1);
    chk("t3 mem_addr", e_addr, 32'h20);
    chk("t3 mem_wdata", e_wdata, 32'hDEADBEEF);
    chk("t3 ack latency", 32'(t_ack - t_req), 32'd3);
    chk("t3 rdata1 kept", rdata1[0], 32'h0);
    do_req(0, 1'b1, 1'b0, 32'h20, 32'h0, t_req, t_en, t_ack, n_en, e_addr, e_we, e_wdata);
    chk("t3 readback", rdata1[0], 32'hDEADBEEF);
    rst[0] = 1'b0;
    req0[0] = 1'b1;
    req1[0] = 1'b1;
    addr0[0] = 32'h100;
    addr1[0] = 32'h200;
    repeat (2) @(negedge clk);
    rst[0] = 1'b1;
    for (int i = 0; i < 60 && order.size() < 4; i++) begin
      @(negedge clk);
      if (ack1[0]) begin
        order.push_back(1);
        tacks.push_back(cyc);
        addr1[0] += 32'h4;
      end
      if (ack0[0]) begin
        order.push_back(0);
        tacks.push_back(cyc);
        addr0[0] += 32'h4;
      end
    end
    req0[0] = 1'b0;
    req1[0] = 1'b0;
    chk("t4 grants", 32'(order.size()), 32'd4);
    for (int i = 0; i < order.size() && i < 4; i++) chk($sformatf("t4 grant %0d", i), 32'(order[i]), 32'(exp_order[i]));
    if (tacks.size() >= 2) chk("t4 spacing", 32'(tacks[1] - tacks[0]), 32'd4);
    do_req(1, 1'b1, 1'b0, 32'h40, 32'h0, t_req, t_en, t_ack, n_en, e_addr, e_we, e_wdata);
    chk("t5 en latency", 32'(t_en - t_req), 32'd1);
    chk("t5 ack latency", 32'(t_ack - t_req), 32'd5);
    chk("t5 rdata1", rdata1[1], 32'h12345678);
    @(negedge clk);
    req0[0] = 1'b1;
    addr0[0] = 32'h30;
    repeat (2) @(negedge clk);
    rst[0] = 1'b0;
    req0[0] = 1'b0;
    @(negedge clk);
    rst[0] = 1'b1;
    cnt = 0;
    repeat (8) begin
      @(negedge clk);
      cnt += int'(ack0[0]) + int'(mem_en[0]);
    end
    chk("t6 quiet after reset", 32'(cnt), 32'd0);
    do_req(0, 1'b0, 1'b0, 32'h10, 32'h0, t_req, t_en, t_ack, n_en, e_addr, e_we, e_wdata);
    chk("t6 ack latency", 32'(t_ack - t_req), 32'd3);
    chk("t6 rdata0", rdata0[0], 32'h00500093);
    repeat (2) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
